conv_window_coord_gen: RTL

- Upstream feeder for the constant address-map stage in the FPGA CNN datapath.
- Walks a convolution kernel window over an IMG_W x IMG_H feature map in raster order.
- Each beat drives PORT_NUM packed x/y coordinate lanes, one per kernel tap, using the same lane-packed bus format the offset mapper consumes.
- Provides valid/ready flow control and start/busy/done frame control.

---
 rtl/cnn_coord_pkg.sv | 21 ++
 rtl/conv_window_lane_calc.sv | 49 ++++
 rtl/conv_window_coord_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cnn_coord_pkg.sv
// cnn_coord_pkg: shared lane packing helpers, FSM state encoding and output-grid math for the CNN coordinate path
package cnn_coord_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int out_dim(input int img, input int k, input int stride, input int pad);
        return (img + 2 * pad - k) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_lane_calc.sv
// conv_window_lane_calc: combinational per-tap x/y lane generator for one window origin
// Optional replicate padding and pad_mask when CONV_WINDOW_COORD_PAD_EN is defined.
module conv_window_lane_calc
    import cnn_coord_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int KERNEL_SIZE = 5,
    parameter int PORT_NUM    = 25,
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int STRIDE      = 1
) (
    input  logic [CNT_W-1:0]          ox,
    input  logic [CNT_W-1:0]          oy,
    output logic [PORT_NUM*WIDTH-1:0] x_bus,
`ifdef CONV_WINDOW_COORD_PAD_EN
    output logic [PORT_NUM*WIDTH-1:0] y_bus,
    output logic [PORT_NUM-1:0]       pad_mask
`else
    output logic [PORT_NUM*WIDTH-1:0] y_bus
`endif
);

`ifdef CONV_WINDOW_COORD_PAD_EN
    localparam int PAD = (KERNEL_SIZE - 1) / 2;
`else
    localparam int PAD = 0;
`endif

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_lane
        localparam int KX = i % KERNEL_SIZE;
        localparam int KY = i / KERNEL_SIZE;
        int xr, yr, xc, yc;
        assign xr = int'(ox) * STRIDE + KX - PAD;
        assign yr = int'(oy) * STRIDE + KY - PAD;
`ifdef CONV_WINDOW_COORD_PAD_EN
        // Replicate padding: taps falling off the map reuse the nearest edge pixel
        assign xc = xr < 0 ? 0 : (xr > IMG_W - 1 ? IMG_W - 1 : xr);
        assign yc = yr < 0 ? 0 : (yr > IMG_H - 1 ? IMG_H - 1 : yr);
        assign pad_mask[i] = (xc != xr) || (yc != yr);
`else
        assign xc = xr;
        assign yc = yr;
`endif
        assign x_bus[lane_lo(i, WIDTH) +: WIDTH] = WIDTH'(xc);
        assign y_bus[lane_lo(i, WIDTH) +: WIDTH] = WIDTH'(yc);
    end

endmodule

// File: rtl/conv_window_coord_gen.sv
// conv_window_coord_gen: raster-order kernel window walker emitting PORT_NUM packed x/y tap lanes per beat
// Optional same/replicate padding and pad_mask output when CONV_WINDOW_COORD_PAD_EN is defined.
module conv_window_coord_gen
    import cnn_coord_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int KERNEL_SIZE = 5,
    parameter int PORT_NUM    = 25,
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int STRIDE      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PORT_NUM*WIDTH-1:0] x_bus,
    output logic [PORT_NUM*WIDTH-1:0] y_bus,
    output logic [15:0]               win_ox,
    output logic [15:0]               win_oy,
`ifdef CONV_WINDOW_COORD_PAD_EN
    output logic                      last,
    output logic [PORT_NUM-1:0]       pad_mask
`else
    output logic                      last
`endif
);

`ifdef CONV_WINDOW_COORD_PAD_EN
    localparam int PAD = (KERNEL_SIZE - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int OUT_W = out_dim(IMG_W, KERNEL_SIZE, STRIDE, PAD);
    localparam int OUT_H = out_dim(IMG_H, KERNEL_SIZE, STRIDE, PAD);
    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(OUT_H - 1);

    if (PORT_NUM != KERNEL_SIZE * KERNEL_SIZE) begin : g_bad_port_num
        $error("PORT_NUM must equal KERNEL_SIZE*KERNEL_SIZE");
    end
    if (OUT_W < 1 || OUT_W > 65535 || OUT_H < 1 || OUT_H > 65535) begin : g_bad_grid
        $error("output grid must be 1..65535 in each axis");
    end

    state_t                    state, state_n;
    logic [CNT_W-1:0]          ox_n, oy_n;
    logic                      ld;
    logic [PORT_NUM*WIDTH-1:0] x_calc, y_calc;
`ifdef CONV_WINDOW_COORD_PAD_EN
    logic [PORT_NUM-1:0]       mask_calc;
`endif

    // Lanes are computed from the next window origin so they land in the output registers with it
    conv_window_lane_calc #(
        .WIDTH       (WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .PORT_NUM    (PORT_NUM),
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .STRIDE      (STRIDE)
    ) u_lane (
        .ox       (ox_n),
        .oy       (oy_n),
        .x_bus    (x_calc),
`ifdef CONV_WINDOW_COORD_PAD_EN
        .y_bus    (y_calc),
        .pad_mask (mask_calc)
`else
        .y_bus    (y_calc)
`endif
    );

    // Next state and next window origin; ld marks a new beat being loaded
    always_comb begin
        state_n = state;
        ox_n    = win_ox;
        oy_n    = win_oy;
        ld      = 1'b0;
        if (state == IDLE && start) begin
            state_n = RUN;
            ox_n    = '0;
            oy_n    = '0;
            ld      = 1'b1;
        end else if (state == RUN && out_ready) begin
            state_n = last ? DONE : RUN;
            ld      = !last;
            ox_n    = last ? win_ox : (win_ox == LAST_X ? '0 : win_ox + 1'b1);
            oy_n    = last ? win_oy : (win_ox == LAST_X ? win_oy + 1'b1 : win_oy);
        end else if (state != RUN) begin
            state_n = IDLE;
        end
    end

    // State register plus fully registered outputs; beat contents only change on a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            win_ox    <= '0;
            win_oy    <= '0;
            x_bus     <= '0;
            y_bus     <= '0;
`ifdef CONV_WINDOW_COORD_PAD_EN
            pad_mask  <= '0;
`endif
        end else begin
            state     <= state_n;
            busy      <= state_n == RUN;
            out_valid <= state_n == RUN;
            done      <= state_n == DONE;
            if (ld) begin
                win_ox   <= ox_n;
                win_oy   <= oy_n;
                x_bus    <= x_calc;
                y_bus    <= y_calc;
                last     <= (ox_n == LAST_X) && (oy_n == LAST_Y);
`ifdef CONV_WINDOW_COORD_PAD_EN
                pad_mask <= mask_calc;
`endif
            end else if (state_n != RUN) begin
                last <= 1'b0;
            end
        end
    end

endmodule
